fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 IQ_DEPTH, 4, instruction-queue entries; power of two, >=2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 imem_req_o  output  1  fetch request valid.
REQ-006 imem_addr_o  output  32  fetch address, bits [1:0] always 0.
REQ-007 imem_gnt_i  input  1  memory accepts request this cycle (handshake = req & gnt).
REQ-008 imem_rvalid_i  input  1  response valid; responses return in request order, latency >=1 cycle.
REQ-009 imem_rdata_i  input  32  instruction word for oldest outstanding request.
REQ-010 redirect_i  input  1  flush and restart fetch (branch/jump resolution, exception).
REQ-011 redirect_pc_i  input  32  restart address; bits [1:0] ignored, treated as 0.
REQ-012 inst_valid_o  output  1  queue head valid toward decode.
REQ-013 inst_o  output  32  head instruction; drives decode inst.
REQ-014 pc_o  output  32  head PC; drives decode pc.
REQ-015 inst_ready_i  input  1  downstream accepts head (pop = inst_valid_o & inst_ready_i).

Function
REQ-016 fetch_pc register holds next request address; imem_addr_o = fetch_pc.
REQ-017 imem_req_o = !redirect_i && (outstanding + iq_count < IQ_DEPTH); credit scheme guarantees queue never overflows.
REQ-018 Once imem_req_o is high, imem_addr_o is held stable until grant, redirect, or reset.
REQ-019 On grant: fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); outstanding += 1.
REQ-020 On imem_rvalid_i: outstanding -= 1; same-cycle grant and response leave outstanding unchanged.
REQ-021 On response with discard_cnt > 0: data dropped, discard_cnt -= 1, resp_pc unchanged.
REQ-022 On response with discard_cnt == 0: push {resp_pc, imem_rdata_i}; resp_pc += 4.
REQ-023 Pushed entry visible on inst_valid_o/inst_o/pc_o the cycle after the response (one-cycle latency); queue bypass is not allowed.
REQ-024 Push and pop in the same cycle are both performed; iq_count unchanged.
REQ-025 Queue empty -> inst_valid_o = 0; inst_o/pc_o hold last values.
REQ-026 Sustained throughput: one instruction per cycle with 1-cycle memory and inst_ready_i held high.
REQ-027 Redirect cycle: imem_req_o forced 0; push and pop are ignored.
REQ-028 Cycle after redirect: fetch_pc = resp_pc = redirect_pc_i & ~3; queue empty.
REQ-029 Cycle after redirect: discard_cnt = outstanding after this cycle's response (all in-flight requests become stale).
REQ-030 Redirect while discard_cnt > 0 recomputes discard_cnt per REQ-029; back-to-back redirects: last one wins.

Reset
REQ-031 While reset is high: imem_req_o = 0, inst_valid_o = 0, inst_o = 0, pc_o = 0.
REQ-032 While reset is high: fetch_pc = resp_pc = RESET_PC; outstanding = discard_cnt = iq_count = 0.
REQ-033 Responses arriving during reset are dropped; reset has priority over redirect.
REQ-034 First request is issued in the first cycle after reset deasserts.

Structure
REQ-035 pipeline_types holds fetch_entry_t {pc[31:0], inst[31:0]} and constant IQ_DEPTH_DEFAULT = 4.
REQ-036 Queue is a separate sub-module, fetch_queue: circular buffer of fetch_entry_t with push/pop/flush and count output.
REQ-037 Counters are sized $clog2(IQ_DEPTH)+1 bits.
REQ-038 inst_o and pc_o connect directly to decode inst and pc.

Verification
REQ-039 Reset release, 1-cycle memory, ready=1 -> PCs 0x0,0x4,0x8... on consecutive cycles; first inst_valid_o 2 cycles after first request.
REQ-040 inst_ready_i=0 for 10 cycles -> exactly 4 entries queued, imem_req_o low, no loss; release -> PCs in order.
REQ-041 Two requests in flight at 3-cycle latency, redirect to 0x100 -> both stale responses dropped; next valid is pc_o=0x100 with 0x100's word.
REQ-042 Redirect with redirect_pc_i=0x103 -> imem_addr_o=0x100.
REQ-043 Fetch from 0xFFFF_FFF8 -> pc_o sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-044 Random gnt stalls, reset mid-stream with 2 in flight -> outputs cleared; restart at RESET_PC; stale responses never appear.

Source files
------------

// File: rtl/pipeline_types.sv
// Shared pipeline payload types and sizing constants for the front end.
package pipeline_types;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned IQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage : pipeline_types

// File: rtl/fetch_queue.sv
// Circular instruction queue with a registered head: a pushed entry is
// visible one cycle after the push, and the head holds its value when empty.
module fetch_queue
    import pipeline_types::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH_DEFAULT,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic         head_valid_o,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           head_valid_q, head_valid_d;
    fetch_entry_t   head_q, head_d;

    // Next-state: the head register is loaded from the post-update storage,
    // so a push into an empty queue lands in the head exactly one cycle later.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        head_valid_d = head_valid_q;
        head_d       = head_q;

        if (flush_i) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            head_valid_d = 1'b0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d      = count_q + CW'(push_i) - CW'(pop_i);
            head_valid_d = (count_d != '0);
            if (count_d != '0) begin
                head_d = mem_d[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_valid_o = head_valid_q;
    assign head_o       = head_q;
    assign count_o      = count_q;

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request generation, in-order response
// capture with stale-response discard after redirect, and a decode-side queue.
module fetch_unit
    import pipeline_types::*;
#(
    parameter logic [31:0]  RESET_PC = 32'h0000_0000,
    parameter int unsigned  IQ_DEPTH = IQ_DEPTH_DEFAULT,
    localparam int unsigned CW       = $clog2(IQ_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        inst_ready_i
);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] iq_count;
    logic [31:0]   redirect_pc_aligned;
    logic          grant;
    logic          push;
    logic          pop;
    fetch_entry_t  push_data;
    fetch_entry_t  head;
    logic          head_valid;

    assign redirect_pc_aligned = redirect_pc_i & ~32'h0000_0003;

    // Requests in flight plus queued entries never exceed the queue size.
    assign imem_req_o  = !reset && !redirect_i &&
                         ((outstanding_q + iq_count) < CW'(IQ_DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign grant       = imem_req_o && imem_gnt_i;

    assign push           = !reset && !redirect_i && imem_rvalid_i && (discard_q == '0);
    assign pop            = !reset && !redirect_i && head_valid && inst_ready_i;
    assign push_data.pc   = resp_pc_q;
    assign push_data.inst = imem_rdata_i;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);

        if (redirect_i) begin
            // Everything still in flight after this cycle is now stale.
            fetch_pc_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            discard_d  = outstanding_d;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rvalid_i) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_queue #(
        .DEPTH (IQ_DEPTH)
    ) u_fetch_queue (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (redirect_i),
        .push_i       (push),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .head_valid_o (head_valid),
        .head_o       (head),
        .count_o      (iq_count)
    );

    assign inst_valid_o = head_valid;
    assign inst_o       = head.inst;
    assign pc_o         = head.pc;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model feeds
// the DUT, expected {pc, inst} pairs are queued by stimulus and checked on pop.
module tb_fetch_unit;
    import pipeline_types::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b1;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_ready_i = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t        pend[$];
    fetch_entry_t exp_q[$];
    int cyc = 0;
    int lat = 1;
    int pops = 0;
    int n_cmp = 0;
    int n_err = 0;
    bit rand_gnt = 1'b0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .IQ_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = start + 32'(4 * i);
            e.inst = word_of(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_pops(input int target, input int budget, output int n);
        n = 0;
        while (pops < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (pops < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_timeout: got %0d pops, required %0d", pops, target);
        end
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(posedge clk); #1;
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        @(posedge clk); #1;
        redirect_i    = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        @(negedge clk);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
    endtask

    // Memory model: records handshakes, returns in order after 'lat' cycles.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rand_gnt) imem_gnt_i = 1'($urandom_range(0, 1));
            imem_rvalid_i = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = word_of(pend[0].addr);
                void'(pend.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (imem_req_o && imem_gnt_i) begin
            pend.push_back('{addr: imem_addr_o, due: cyc + lat});
        end
    end

    // Monitor: every accepted instruction must match the scoreboard head.
    always @(negedge clk) begin : mon
        fetch_entry_t e;
        if (!reset && !redirect_i && inst_valid_o && inst_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got pc %h, required no instruction", pc_o);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", pc_o, e.pc);
                chk("pop_inst", inst_o, e.inst);
            end
            pops++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;

        // Reset, then streaming at 1-cycle latency with ready held high.
        repeat (2) @(posedge clk);
        chk_reset_outputs();
        expect_seq(32'h0, 8);
        @(posedge clk); #1;
        inst_ready_i = 1'b1;
        reset        = 1'b0;
        @(negedge clk);
        chk("first_req", 32'(imem_req_o), 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);
        wait_pops(pops + 8, 50, n);
        chk("stream_cycles", 32'(n), 32'd10);
        inst_ready_i = 1'b0;

        // Back-pressure fills the queue, then drain with memory stalled.
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("full_req", 32'(imem_req_o), 32'd0);
        chk("full_valid", 32'(inst_valid_o), 32'd1);
        chk("full_head_pc", pc_o, 32'h20);
        @(posedge clk); #1;
        imem_gnt_i   = 1'b0;
        inst_ready_i = 1'b1;
        expect_seq(32'h20, 4);
        base = pops;
        repeat (8) @(posedge clk);
        #1;
        chk("drain_count", 32'(pops - base), 32'd4);
        chk("stall_req", 32'(imem_req_o), 32'd1);
        chk("stall_addr", imem_addr_o, 32'h30);
        imem_gnt_i = 1'b1;
        expect_seq(32'h30, 4);
        wait_pops(pops + 4, 50, n);
        inst_ready_i = 1'b0;

        // Two requests in flight at 3-cycle latency, then redirect to 0x100.
        lat = 3;
        do_redirect(32'h200);
        @(posedge clk); #1;
        @(posedge clk); #1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        inst_ready_i  = 1'b1;
        expect_seq(32'h100, 4);
        @(posedge clk); #1;
        redirect_i = 1'b0;
        @(negedge clk);
        chk("redir_addr", imem_addr_o, 32'h100);
        chk("redir_empty", 32'(inst_valid_o), 32'd0);
        wait_pops(pops + 4, 100, n);
        inst_ready_i = 1'b0;

        // Misaligned redirect target is word-aligned.
        lat = 1;
        do_redirect(32'h103);
        inst_ready_i = 1'b1;
        expect_seq(32'h100, 2);
        @(negedge clk);
        chk("align_addr", imem_addr_o, 32'h100);
        wait_pops(pops + 2, 50, n);
        inst_ready_i = 1'b0;

        // Address wrap at the top of the address space.
        do_redirect(32'hFFFF_FFF8);
        inst_ready_i = 1'b1;
        expect_seq(32'hFFFF_FFF8, 4);
        wait_pops(pops + 4, 50, n);
        inst_ready_i = 1'b0;

        // Random grant stalls at 3-cycle latency.
        lat      = 3;
        rand_gnt = 1'b1;
        do_redirect(32'h400);
        inst_ready_i = 1'b1;
        expect_seq(32'h400, 8);
        wait_pops(pops + 8, 300, n);
        inst_ready_i = 1'b0;
        rand_gnt     = 1'b0;
        imem_gnt_i   = 1'b1;

        // Reset with two requests in flight; their responses land during reset.
        do_redirect(32'h500);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        repeat (4) chk_reset_outputs();
        @(posedge clk); #1;
        lat = 1;
        expect_seq(32'h0, 4);
        inst_ready_i = 1'b1;
        reset        = 1'b0;
        wait_pops(pops + 4, 50, n);
        inst_ready_i = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_unit
